// File: rtl/uart_pkg.sv
// Shared UART-Tx types and constants: serializer FSM states, default frame width
// and the idle level of the serial line.
package uart_pkg;

  localparam int   UART_FRAME_W  = 11;
  localparam logic TX_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT
  } tx_ser_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Frame hand-off between the UART-Tx frame generator (master) and the
// serializer (slave).
interface uart_tx_serializer_if #(
  parameter int FRAME_W = uart_pkg::UART_FRAME_W
);
  // A frame moves on every rising edge where FrameValid and FrameReady are both 1.
  // The master holds FrameIn steady while FrameValid is high and may drop
  // FrameValid before the transfer without side effects.
  logic [FRAME_W-1:0] FrameIn;
  logic               FrameValid;
  logic               FrameReady;

  modport master (
    output FrameIn,
    output FrameValid,
    input  FrameReady
  );

  modport slave (
    input  FrameIn,
    input  FrameValid,
    output FrameReady
  );
endinterface

// File: rtl/uart_tx_holdreg.sv
// One-entry holding register in front of the serializer. A frame offered while
// the consumer takes the incoming word directly (Bypass) is not stored.
module uart_tx_holdreg #(
  parameter int W = 11
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] InData,
  input  logic         InValid,
  output logic         InReady,
  input  logic         Bypass,
  input  logic         Pop,
  output logic         Full,
  output logic [W-1:0] HeldData
);

  logic         full;
  logic [W-1:0] heldData;

  assign InReady  = !full;
  assign Full     = full;
  assign HeldData = heldData;

  // Push needs an empty entry and Pop needs a full one, so they never coincide.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      full <= 1'b0;
    end else if (InValid && !full && !Bypass) begin
      full     <= 1'b1;
      heldData <= InData;
    end else if (Pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART-Tx parallel-in/serial-out stage: shifts a pre-built frame LSB-first, one bit
// per BaudTick. Optional macro UART_TX_SKID_EN adds a one-entry holding register.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int FRAME_W = UART_FRAME_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 BaudTick,
  uart_tx_serializer_if.slave  bus,
  output logic                 TxOut,
  output logic                 Busy,
  output logic                 FrameDone,
  output tx_ser_state_t        DbgState
);

  localparam int              CNT_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  tx_ser_state_t      state;
  logic [CNT_W-1:0]   bitCnt;
  logic [FRAME_W-1:0] shiftReg;

  logic               endTick;
  logic               startFrame;
  logic               reloadAvail;
  logic [FRAME_W-1:0] startData;
  logic [FRAME_W-1:0] reloadData;

  assign endTick  = (state == SHIFT) && BaudTick && (bitCnt == LAST_BIT);
  assign DbgState = state;

`ifdef UART_TX_SKID_EN
  logic               holdFull;
  logic               holdReady;
  logic               holdPop;
  logic               holdBypass;
  logic [FRAME_W-1:0] holdData;

  // In IDLE an empty holding register is bypassed so a frame arms immediately.
  assign holdBypass = (state == IDLE) && !holdFull;
  assign holdPop    = holdFull && ((state == IDLE) || endTick);

  uart_tx_holdreg #(.W(FRAME_W)) u_holdreg (
    .Clock    (Clock),
    .Reset    (Reset),
    .InData   (bus.FrameIn),
    .InValid  (bus.FrameValid),
    .InReady  (holdReady),
    .Bypass   (holdBypass),
    .Pop      (holdPop),
    .Full     (holdFull),
    .HeldData (holdData)
  );

  assign bus.FrameReady = holdReady;
  assign startFrame     = (state == IDLE) && (holdFull || bus.FrameValid);
  assign startData      = holdFull ? holdData : bus.FrameIn;
  assign reloadAvail    = holdFull;
  assign reloadData     = holdData;
`else
  assign bus.FrameReady = (state == IDLE);
  assign startFrame     = (state == IDLE) && bus.FrameValid;
  assign startData      = bus.FrameIn;
  assign reloadAvail    = 1'b0;
  assign reloadData     = bus.FrameIn;
`endif

  // The line bit is driven from shiftReg[0] and the register refills with idle 1s.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '1;
      TxOut     <= TX_IDLE_LEVEL;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      FrameDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (startFrame) begin
            shiftReg <= startData;
            Busy     <= 1'b1;
            state    <= ARM;
          end
        end
        ARM: begin
          if (BaudTick) begin
            TxOut    <= shiftReg[0];
            shiftReg <= {TX_IDLE_LEVEL, shiftReg[FRAME_W-1:1]};
            bitCnt   <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (BaudTick) begin
            if (bitCnt == LAST_BIT) begin
              FrameDone <= 1'b1;
              if (reloadAvail) begin
                TxOut    <= reloadData[0];
                shiftReg <= {TX_IDLE_LEVEL, reloadData[FRAME_W-1:1]};
                bitCnt   <= '0;
              end else begin
                TxOut <= TX_IDLE_LEVEL;
                Busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              TxOut    <= shiftReg[0];
              shiftReg <= {TX_IDLE_LEVEL, shiftReg[FRAME_W-1:1]};
              bitCnt   <= bitCnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
